// File: rtl/nubus_pkg.sv
// Shared NuBus slave-port types: FSM states, ack status codes, byte-lane and block-length decode.
package nubus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_ACK  = 2'd2,
    ST_NEXT = 2'd3
  } nub_state_e;

  typedef enum logic [1:0] {
    ACK_COMPLETE = 2'b00,
    ACK_ERROR    = 2'b01
  } nub_ack_e;

  localparam int unsigned TMO_W = 10;

  // TM0=0 selects a single byte lane; TM0=1 selects word, low half or high half.
  function automatic logic [3:0] wstrb_decode(input logic [1:0] a_lo, input logic tm0);
    logic [3:0] strb;
    if (!tm0) begin
      strb = 4'b0001 << a_lo;
    end else begin
      case (a_lo)
        2'b01:   strb = 4'h3;
        2'b10:   strb = 4'hC;
        default: strb = 4'hF;
      endcase
    end
    return strb;
  endfunction

  // Beat count minus one for a block transfer: 2/4/8/16 beats.
  function automatic logic [3:0] block_len_m1(input logic [1:0] sel);
    logic [3:0] len;
    case (sel)
      2'b00:   len = 4'd1;
      2'b01:   len = 4'd3;
      2'b10:   len = 4'd7;
      default: len = 4'd15;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/nubus_addr_decode.sv
// Combinational slot/window address decode; own slot wins, then lowest window index.
module nubus_addr_decode
  import nubus_pkg::*;
#(
  parameter int unsigned         N_WIN    = 2,
  parameter logic [N_WIN*12-1:0] WIN_BASE = '0,
  parameter logic [N_WIN*12-1:0] WIN_MASK = {N_WIN{12'hFFF}}
) (
  input  logic [11:0] addr_hi,
  input  logic [3:0]  nub_idn,
  output logic        hit,
  output logic [3:0]  win
);

  always_comb begin
    hit = 1'b0;
    win = 4'd0;
    for (int k = N_WIN - 1; k >= 0; k--) begin
      if (((addr_hi ^ WIN_BASE[k*12 +: 12]) & WIN_MASK[k*12 +: 12]) == 12'h000) begin
        hit = 1'b1;
        win = 4'(k + 1);
      end
    end
    if (addr_hi[11:8] == 4'hF && addr_hi[7:4] == ~nub_idn) begin
      hit = 1'b1;
      win = 4'd0;
    end
  end

endmodule

// File: rtl/nubus_slave_port.sv
// NuBus slave port bridging bus transactions to a simple memory request interface.
// Block transfers are enabled by defining NUBUS_BLOCK_XFER_EN.
//
// state | meaning
// IDLE  | waiting for an address cycle that hits slot or window space
// MEM   | memory request outstanding, timeout counting down
// ACK   | ack driven for one cycle, read data on the bus
// NEXT  | block gap cycle before the next beat's request
module nubus_slave_port
  import nubus_pkg::*;
#(
  parameter int unsigned         N_WIN       = 2,
  parameter logic [N_WIN*12-1:0] WIN_BASE    = '0,
  parameter logic [N_WIN*12-1:0] WIN_MASK    = {N_WIN{12'hFFF}},
  parameter int unsigned         TIMEOUT_CYC = 255
) (
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic [3:0]  nub_idn,
  input  logic        nub_startn,
  inout  wire  [31:0] nub_adn,
  inout  wire         nub_tm1n,
  inout  wire         nub_tm0n,
  inout  wire         nub_ackn,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_win,
  output logic        slv_busy
);

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  nub_state_e        state_q, state_d;
  logic [31:0]       addr_l, rdata_q;
  logic              tm1_l, tm0_l, addr_cyc, hit, blk_req, unsup_blk;
  logic              is_wr_q, err_q, wait_q, ack_drv;
  logic [3:0]        win, beats_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [1:0]        ack_st;

  assign addr_l   = ~nub_adn;
  assign tm1_l    = ~nub_tm1n;
  assign tm0_l    = ~nub_tm0n;
  assign addr_cyc = !nub_startn && (nub_ackn == 1'b1);
  assign blk_req  = tm0_l && (addr_l[1:0] == 2'b11);

`ifdef NUBUS_BLOCK_XFER_EN
  assign unsup_blk = 1'b0;
`else
  assign unsup_blk = blk_req;
`endif

  nubus_addr_decode #(
    .N_WIN    (N_WIN),
    .WIN_BASE (WIN_BASE),
    .WIN_MASK (WIN_MASK)
  ) u_decode (
    .addr_hi (addr_l[31:20]),
    .nub_idn (nub_idn),
    .hit     (hit),
    .win     (win)
  );

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (addr_cyc && hit) state_d = unsup_blk ? ST_ACK : ST_MEM;
      ST_MEM:  if ((mem_valid && mem_ready) || tmo_q == '0) state_d = ST_ACK;
      ST_ACK:  state_d = (!err_q && beats_q != 4'd0) ? ST_NEXT : ST_IDLE;
      ST_NEXT: state_d = ST_MEM;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      mem_win   <= '0;
      rdata_q   <= '0;
      is_wr_q   <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= 1'b0;
      beats_q   <= '0;
      tmo_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (addr_cyc && hit) begin
          is_wr_q   <= ~tm1_l;
          wait_q    <= ~tm1_l & ~unsup_blk;
          err_q     <= unsup_blk;
          mem_win   <= win;
          tmo_q     <= TMO_LOAD;
          beats_q   <= '0;
          mem_addr  <= addr_l;
          mem_wstrb <= tm1_l ? 4'h0 : wstrb_decode(addr_l[1:0], tm0_l);
`ifdef NUBUS_BLOCK_XFER_EN
          if (blk_req) begin
            mem_addr <= {addr_l[31:6], 6'd0};
            beats_q  <= block_len_m1(addr_l[3:2]);
          end
`endif
        end
        ST_MEM: begin
          // Write data arrives one cycle after the address; request is held back until then.
          if (wait_q) begin
            mem_wdata <= addr_l;
            wait_q    <= 1'b0;
          end
          if (mem_valid && mem_ready) begin
            rdata_q <= mem_rdata;
          end else if (tmo_q == '0) begin
            err_q   <= 1'b1;
            beats_q <= '0;
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
          end
        end
        ST_ACK: if (state_d == ST_NEXT) begin
          beats_q  <= beats_q - 4'd1;
          mem_addr <= mem_addr + 32'd4;
        end
        ST_NEXT: begin
          tmo_q  <= TMO_LOAD;
          wait_q <= is_wr_q;
        end
        default: ;
      endcase
    end
  end

  assign mem_valid = (state_q == ST_MEM) && !wait_q;
  assign slv_busy  = (state_q != ST_IDLE);
  assign ack_drv   = (state_q == ST_ACK);
  assign ack_st    = err_q ? ACK_ERROR : ACK_COMPLETE;

  assign nub_ackn = ack_drv ? 1'b0 : 1'bz;
  assign nub_tm1n = ack_drv ? ~ack_st[1] : 1'bz;
  assign nub_tm0n = ack_drv ? ~ack_st[0] : 1'bz;
  assign nub_adn  = (ack_drv && !is_wr_q && !err_q) ? ~rdata_q : 32'bz;

endmodule

// File: doc/nubus_slave_port.md
NUBUS_SLAVE_PORT -- requirements
Module: nubus_slave_port

Interface
REQ-001 N_WIN, 2, number of address windows decoded besides own slot space (1..8).
REQ-002 WIN_BASE, 0, packed N_WIN x 12-bit window bases compared against logical address bits [31:20].
REQ-003 WIN_MASK, 'hFFF per window, packed N_WIN x 12-bit compare masks.
REQ-004 TIMEOUT_CYC, 255, maximum nub_clkn cycles waiting for mem_ready before an error ack (8..1023).
REQ-005 nub_clkn  input  1  NuBus clock; all state changes on its rising edge.
REQ-006 nub_resetn  input  1  reset; asynchronous, active-low.
REQ-007 nub_idn  input  4  slot ID, active-low.
REQ-008 nub_startn  input  1  transaction start, active-low.
REQ-009 nub_adn  inout  32  address/data, active-low, tri-stated when not driving.
REQ-010 nub_tm1n, nub_tm0n  inout  1 each  transfer mode in; ack status out; tri-stated otherwise.
REQ-011 nub_ackn  inout  1  acknowledge, driven low one cycle per completed beat, else tri-stated.
REQ-012 mem_valid/mem_addr[31:0]/mem_wdata[31:0]/mem_wstrb[3:0]  output  memory request.
REQ-013 mem_ready  input  1; mem_rdata  input  32  memory response.
REQ-014 mem_win  output  4  decoded target: 0 = own slot, 1..N_WIN = window index.
REQ-015 slv_busy  output  1  high from address cycle capture until final ack.

Function
REQ-016 Logical address A = ~nub_adn sampled when nub_startn=0 and nub_ackn=1; own slot hit when A[31:28]=4'hF and A[27:24]=~nub_idn; window k hit when (A[31:20]^WIN_BASE[k])&WIN_MASK[k]==0; lowest index wins.
REQ-017 Miss: no state change, no bus drive, mem_valid stays 0.
REQ-018 FSM states IDLE, MEM, ACK, NEXT; IDLE->MEM on hit; MEM->ACK on mem_ready or timeout; ACK->IDLE after final beat, ACK->NEXT otherwise; NEXT->MEM after one cycle.
REQ-019 Write (logical TM1=0): mem_wdata = ~nub_adn sampled in the cycle after start; mem_wstrb from A[1:0] and TM0: word (A[1:0]=00, TM0=1) 4'hF; half TM0=1 A[1]=0 -> 4'h3, A[1]=1 -> 4'hC; byte TM0=0 -> one-hot lane A[1:0].
REQ-020 Read: mem_rdata registered on mem_ready, driven inverted on nub_adn during the ACK cycle only.
REQ-021 mem_valid high in MEM only; request fields stable until mem_ready.
REQ-022 Ack status on logical TM1:TM0: 00 complete, 01 error (timeout); driven only during ACK cycle.
REQ-023 Timeout counter loads at MEM entry; reaching TIMEOUT_CYC forces ACK with error, drops mem_valid, aborts remaining block beats.
REQ-024 nub_startn asserted while busy is ignored.

Reset
REQ-025 nub_resetn=0: state IDLE, all nub_* outputs tri-stated, mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, mem_win=0, slv_busy=0, counters 0; reset mid-transaction abandons it without an ack.

Configuration
REQ-026 NUBUS_BLOCK_XFER_EN defined: word request with A[1:0]=11 is a block transfer of 2/4/8/16 beats from A[3:2]=00/01/10/11, base address A with bits [5:2] cleared to block alignment, mem_addr incrementing by 4 per beat, one ack per beat, status complete on every beat.
REQ-027 NUBUS_BLOCK_XFER_EN undefined: A[1:0]=11 word request acks once with error status, no memory access; NEXT state absent.

Structure
REQ-028 Shared package nubus_pkg: state enum, ack status codes, wstrb decode function, block-length decode.
REQ-029 One sub-module nubus_addr_decode (slot + window compare, mem_win output), combinational.

Verification
REQ-030 ID=3, start with A=32'hF3000004, TM1=0 TM0=1, data 32'hDEADBEEF, ready 2 cycles later -> mem_addr F3000004, wstrb F, one ack status 00.
REQ-031 Byte write A=F3000002 TM0=0 -> wstrb 4'h4; half write A=F3000002 TM0=1 -> wstrb 4'hC.
REQ-032 Read A=F3000010, mem_rdata 12345678 -> nub_adn = ~32'h12345678 in ack cycle only, tri-stated next cycle.
REQ-033 WIN_BASE[0]=12'h400, mask FF0, A=40080000 -> mem_win=1; A=F5000000 with ID=3 -> no response.
REQ-034 mem_ready never asserted, TIMEOUT_CYC=8 -> ack with status 01 after 8 cycles, slv_busy falls.
REQ-035 NUBUS_BLOCK_XFER_EN, A=F300001F (A[3:2]=11) read -> 16 beats at F3000000..F300003C, 16 acks; reset asserted at beat 5 -> bus released immediately, no further ack.
